// File: rtl/fetch_pkg.sv
// fetch_pkg: constants and entry type shared by the fetch stage and the control unit.
package fetch_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [XLEN-1:0] NOP_INSTR = {25'd0, OP_IMM};
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetched {instr, pc} entries with synchronous flush.
module fetch_queue import fetch_pkg::*; #(
  parameter type T = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  T           i_din,
  output T           o_head,
  output logic [1:0] o_count
);
  T r_mem [2];
  logic r_rd, r_wr;
  logic [1:0] r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_rd <= 1'b0;
      r_wr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      r_rd <= r_rd ^ i_pop;
      r_wr <= r_wr ^ i_push;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end
  // storage needs no reset: entries are only visible through r_count
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  end
  assign o_head = r_mem[r_rd];
  assign o_count = r_count;
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner issuing single-outstanding imem reads, buffering 2 instructions for decode
// and redirecting/flushing on taken branches reported back by decode.
module fetch_unit import fetch_pkg::*; #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  PCsrc,
  input  logic [ADDR_WIDTH-1:0] ImmOp
);
  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;
  logic [ADDR_WIDTH-1:0] r_pc, r_req_pc;
  logic r_out, r_kill;
  logic [1:0] w_count;
  entry_t w_head, w_din;
  logic w_accept, w_redirect, w_hs, w_rsp, w_push;
  assign instr_valid = w_count != 2'd0;
  assign w_accept = instr_valid & instr_ready;
  assign w_redirect = w_accept & PCsrc;
  // count + outstanding never exceeds 2, so a response always has room
  assign imem_req_valid = en & ~r_out & (w_count < 2'd2) & ~w_redirect;
  assign imem_addr = {r_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_hs = imem_req_valid & imem_req_ready;
  assign w_rsp = imem_rsp_valid & r_out;
  assign w_push = w_rsp & ~r_kill;
  assign w_din = '{instr: imem_rsp_data, pc: r_req_pc};
  assign instr = instr_valid ? w_head.instr : DATA_WIDTH'(NOP_INSTR);
  assign instr_pc = instr_valid ? w_head.pc : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_PC;
      r_req_pc <= '0;
      r_out <= 1'b0;
      r_kill <= 1'b0;
    end else begin
      r_pc <= w_redirect ? instr_pc + ImmOp : w_hs ? r_pc + ADDR_WIDTH'(4) : r_pc;
      r_req_pc <= w_hs ? r_pc : r_req_pc;
      r_out <= w_hs | (r_out & ~imem_rsp_valid);
      // a wrong-path response still in flight must be dropped when it lands
      r_kill <= w_redirect ? (r_out & ~imem_rsp_valid) : (r_kill & ~w_rsp);
    end
  end
  fetch_queue #(.T(entry_t)) u_queue (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_accept),
    .i_flush (w_redirect),
    .i_din   (w_din),
    .o_head  (w_head),
    .o_count (w_count)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a program-order fetch model.
module tb_fetch_unit;
  import fetch_pkg::*;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic [31:0] instr, instr_pc;
  logic instr_valid, instr_ready = 1'b0, PCsrc = 1'b0;
  logic [31:0] ImmOp = '0;
  int total = 0, bad = 0, cyc = 0, n_acc = 0, n_hs = 0, mem_lat = 1;
  logic [31:0] exp_pc = '0, exp_issue = '0, salt = '0;
  logic [31:0] pend_addr[$];
  int pend_due[$];

  fetch_unit dut (
    .clk(clk), .rst(rst), .en(en),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .PCsrc(PCsrc), .ImmOp(ImmOp)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ salt;
  endfunction

  // scoreboard: delivered stream follows program order, issue stream is sequential from the last target
  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst) begin
      exp_pc = 32'h0;
      exp_issue = 32'h0;
    end else begin
      if (instr_valid && instr_ready) begin
        n_acc++;
        total++;
        if (instr_pc !== exp_pc || instr !== mem_word(exp_pc)) begin
          bad++;
          $display("FAIL accept: got pc=%h instr=%h, want pc=%h instr=%h", instr_pc, instr, exp_pc, mem_word(exp_pc));
        end
        exp_pc = PCsrc ? exp_pc + ImmOp : exp_pc + 32'd4;
        if (PCsrc) exp_issue = exp_pc;
      end
      if (imem_req_valid && imem_req_ready) begin
        n_hs++;
        total++;
        if (imem_addr !== exp_issue) begin
          bad++;
          $display("FAIL issue_addr: got %h want %h", imem_addr, exp_issue);
        end
        exp_issue = exp_issue + 32'd4;
        pend_addr.push_back(imem_addr);
        pend_due.push_back(cyc + mem_lat - 1);
      end
    end
  end

  // in-order memory that ignores reset and answers mem_lat cycles after the handshake
  initial forever begin
    @(negedge clk);
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = mem_word(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data = $urandom;
    end
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; en = 1'b0; instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    salt = $urandom;
    repeat (3) @(negedge clk);
    total += 4;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    if (instr !== NOP_INSTR) begin bad++; $display("FAIL rst_instr: got %h want %h", instr, NOP_INSTR); end
    if (instr_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req_valid); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL en_low_req: got %b want 0", imem_req_valid); end
  endtask

  task automatic test_sequential();
    int a0, h0;
    a0 = n_acc; h0 = n_hs;
    mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1; en = 1'b1;
    repeat (12) @(negedge clk);
    total += 2;
    if (n_acc - a0 < 4) begin bad++; $display("FAIL seq_accepts: got %0d want >=4", n_acc - a0); end
    if (n_hs - h0 < 5) begin bad++; $display("FAIL seq_issues: got %0d want >=5", n_hs - h0); end
  endtask

  task automatic test_backpressure();
    int h1;
    bit ok;
    instr_ready = 1'b0;
    repeat (4) @(negedge clk);
    h1 = n_hs; ok = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b1) ok = 1'b0;
    end
    total++;
    if (!ok || n_hs != h1) begin bad++; $display("FAIL full_stall: got ok=%0b new_issues=%0d want ok=1 new_issues=0", ok, n_hs - h1); end
    en = 1'b0; instr_ready = 1'b1;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1) begin bad++; $display("FAIL second_entry: got valid=%b want 1", instr_valid); end
    @(negedge clk);
    instr_ready = 1'b0;
    total += 2;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL drained: got valid=%b want 0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL en0_req: got %b want 0", imem_req_valid); end
  endtask

  task automatic test_redirect();
    bit found = 1'b0;
    reset_dut();
    mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (instr_valid && instr_pc == 32'h8) begin instr_ready = 1'b0; found = 1'b1; break; end
    end
    for (int i = 0; i < 20; i++) begin
      if (pend_addr.size() > 0) break;
      @(negedge clk);
    end
    total++;
    if (!found || pend_addr.size() == 0) begin bad++; $display("FAIL redir_setup: got found=%0b inflight=%0d want 1 1", found, pend_addr.size()); end
    instr_ready = 1'b1; PCsrc = 1'b1; ImmOp = 32'hFFFF_FFF8;
    @(negedge clk);
    PCsrc = 1'b0; ImmOp = '0;
    total += 2;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL redir_flush: got valid=%b want 0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL redir_req: got %b want 0", imem_req_valid); end
    for (int i = 0; i < 50; i++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL redir_target: got valid=%b pc=%h want 1 00000000", instr_valid, instr_pc); end
    @(negedge clk);
    instr_ready = 1'b0;
  endtask

  task automatic test_req_stall();
    bit ok = 1'b1;
    reset_dut();
    mem_lat = 1; imem_req_ready = 1'b0; instr_ready = 1'b1; en = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL req_hold: got valid=%b addr=%h want stable 1 00000000", imem_req_valid, imem_addr); end
    imem_req_ready = 1'b1;
    @(negedge clk);
    total++;
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL req_single: got %b want 0", imem_req_valid); end
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      @(negedge clk);
    end
    total++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h4) begin bad++; $display("FAIL req_next: got valid=%b addr=%h want 1 00000004", imem_req_valid, imem_addr); end
  endtask

  task automatic test_wrap();
    logic [31:0] pcs [6];
    logic [31:0] imms [6];
    bit brs [6];
    int k = 0;
    pcs = '{32'h0, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFF8, 32'h8};
    imms = '{32'hFFFF_FFF8, 32'h0, 32'h0, 32'hFFFF_FFF8, 32'h10, 32'h0};
    brs = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    reset_dut();
    mem_lat = 1; imem_req_ready = 1'b1; en = 1'b1;
    for (int i = 0; i < 200 && k < 6; i++) begin
      @(negedge clk);
      instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
      if (instr_valid) begin
        total++;
        if (instr_pc !== pcs[k]) begin bad++; $display("FAIL wrap_pc%0d: got %h want %h", k, instr_pc, pcs[k]); end
        instr_ready = 1'b1; PCsrc = brs[k]; ImmOp = imms[k];
        k++;
      end
    end
    @(negedge clk);
    instr_ready = 1'b0; PCsrc = 1'b0; ImmOp = '0;
    total++;
    if (k != 6) begin bad++; $display("FAIL wrap_timeout: got %0d want 6 accepts", k); end
  endtask

  task automatic test_reset_mid();
    bit ok = 1'b1;
    reset_dut();
    mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b0; en = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (instr_valid && pend_addr.size() > 0) break;
    end
    total++;
    if (!(instr_valid && pend_addr.size() > 0)) begin bad++; $display("FAIL mid_setup: got valid=%b inflight=%0d want 1 1", instr_valid, pend_addr.size()); end
    rst = 1'b1; en = 1'b0;
    #1;
    total += 4;
    if (instr_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", instr_valid); end
    if (imem_req_valid !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", imem_req_valid); end
    if (instr !== NOP_INSTR) begin bad++; $display("FAIL mid_instr: got %h want %h", instr, NOP_INSTR); end
    if (instr_pc !== 32'h0) begin bad++; $display("FAIL mid_pc: got %h want 0", instr_pc); end
    @(negedge clk);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) ok = 1'b0;
    end
    total++;
    if (!ok) begin bad++; $display("FAIL stray_rsp: got valid=%b req=%b want 0 0", instr_valid, imem_req_valid); end
    en = 1'b1; instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) break;
      @(negedge clk);
    end
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin bad++; $display("FAIL mid_restart: got valid=%b pc=%h want 1 00000000", instr_valid, instr_pc); end
  endtask

  task automatic test_random();
    int a0, off;
    reset_dut();
    a0 = n_acc;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!imem_req_valid) en = $urandom_range(0, 9) != 0;
      imem_req_ready = $urandom_range(0, 3) != 0;
      instr_ready = $urandom_range(0, 2) != 0;
      PCsrc = $urandom_range(0, 7) == 0;
      off = $urandom_range(0, 32);
      ImmOp = 32'((off - 16) * 4);
      if (pend_addr.size() == 0) mem_lat = $urandom_range(1, 3);
    end
    @(negedge clk);
    instr_ready = 1'b0; PCsrc = 1'b0;
    total++;
    if (n_acc - a0 < 30) begin bad++; $display("FAIL rand_progress: got %0d want >=30 accepts", n_acc - a0); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect();
    test_req_stall();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
